// File: rtl/lcd_rd_ctrl.sv
// lcd_rd_ctrl: frame-buffer read scheduler for the LCD output path.
// Once per frame (rising edge of out_vsync) it clears the pixel FIFO and then
// issues burst reads to the memory controller. A new burst is issued whenever
// the FIFO level drops below the low watermark, until the whole frame
// (h_disp * v_disp words) has been fetched.
//
// Handshake: rd_req is held high, with rd_addr/rd_len stable, until rd_ack
// is sampled high; rd_req is low on the following cycle. rd_done is a
// one-cycle pulse that ends the accepted burst. rd_ack and rd_done are
// ignored outside REQ and XFER.
//
// Optional build macro: LCD_RD_UNDERRUN_CNT_EN enables the saturating
// frame-overrun counter on underrun_cnt; without it underrun_cnt is 0.
module lcd_rd_ctrl #(
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] FB_BASE    = '0,
  parameter int                BURST_LEN  = 128,
  parameter int                LOW_WM     = 512,
  parameter int                CLR_CYCLES = 4
) (
  input  logic              lcd_pclk,
  input  logic              rst,
  input  logic [10:0]       h_disp,
  input  logic [10:0]       v_disp,
  input  logic              out_vsync,
  input  logic [10:0]       fifo_usedw,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [10:0]       rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              fifo_clr,
  output logic              frame_done,
  output logic              busy,
  output logic [15:0]       underrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WAIT  = 3'd2,
    S_REQ   = 3'd3,
    S_XFER  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0]  CLR_LAST  = 8'(CLR_CYCLES - 1);
  localparam logic [10:0] BURST_W   = 11'(BURST_LEN);
  localparam logic [11:0] LOW_WM_W  = 12'(LOW_WM);

  state_t            state;
  logic              vsync_d;
  logic              pend;
  logic [7:0]        clr_cnt;
  logic [20:0]       remaining;
  logic [ADDR_W-1:0] next_addr;

  logic              vs_rise;
  logic              restart;
  logic              fifo_low;
  logic [20:0]       frame_words;
  logic [10:0]       next_len;

  assign vs_rise     = out_vsync & ~vsync_d;
  assign fifo_low    = {1'b0, fifo_usedw} < LOW_WM_W;
  assign frame_words = 21'(h_disp) * 21'(v_disp);
  assign next_len    = (remaining < {10'd0, BURST_W}) ? remaining[10:0] : BURST_W;
  assign busy        = (state != S_IDLE);

  // Decide whether this cycle starts a fresh frame (from idle or as an overrun).
  // An accepted burst is never cut short: an overrun during it is deferred
  // through pend until its rd_done.
  always_comb begin
    restart = 1'b0;
    case (state)
      S_IDLE, S_CLEAR, S_WAIT, S_DONE: restart = vs_rise;
      S_REQ:                           restart = vs_rise & ~rd_ack;
      S_XFER:                          restart = rd_done & (pend | vs_rise);
      default:                         restart = 1'b0;
    endcase
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      state      <= S_IDLE;
      vsync_d    <= 1'b0;
      pend       <= 1'b0;
      clr_cnt    <= '0;
      remaining  <= '0;
      next_addr  <= FB_BASE;
      rd_req     <= 1'b0;
      rd_addr    <= FB_BASE;
      rd_len     <= '0;
      fifo_clr   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vsync_d    <= out_vsync;
      frame_done <= 1'b0;
      if (restart) begin
        state     <= S_CLEAR;
        fifo_clr  <= 1'b1;
        clr_cnt   <= '0;
        remaining <= frame_words;
        next_addr <= FB_BASE;
        rd_req    <= 1'b0;
        pend      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
          end
          S_CLEAR: begin
            if (clr_cnt == CLR_LAST) begin
              fifo_clr <= 1'b0;
              state    <= S_WAIT;
            end else begin
              clr_cnt <= clr_cnt + 8'd1;
            end
          end
          S_WAIT: begin
            if (remaining == '0) begin
              state      <= S_DONE;
              frame_done <= 1'b1;
            end else if (fifo_low) begin
              state   <= S_REQ;
              rd_req  <= 1'b1;
              rd_addr <= next_addr;
              rd_len  <= next_len;
            end
          end
          S_REQ: begin
            if (rd_ack) begin
              rd_req <= 1'b0;
              pend   <= vs_rise;
              state  <= S_XFER;
            end
          end
          S_XFER: begin
            if (rd_done) begin
              next_addr <= next_addr + ADDR_W'(rd_len);
              remaining <= remaining - {10'd0, rd_len};
              state     <= S_WAIT;
            end else if (vs_rise) begin
              pend <= 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef LCD_RD_UNDERRUN_CNT_EN
  logic        overrun;
  logic [15:0] urun;

  assign overrun      = vs_rise & (state != S_IDLE) & (state != S_DONE);
  assign underrun_cnt = urun;

  // Count frame starts that arrive before the previous frame finished.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      urun <= '0;
    end else if (overrun && (urun != 16'hFFFF)) begin
      urun <= urun + 16'd1;
    end
  end
`else
  assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lcd_rd_ctrl.sv
// Bench for lcd_rd_ctrl: a frame table driven through a simple memory
// controller responder, plus hand sequences for held vsync, watermark,
// reset and mid-burst frame overrun. A second instance with a high FB_BASE
// shares all inputs and exercises address wrap.
module tb_lcd_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h_disp, v_disp, fifo_usedw;
  logic        out_vsync, rd_ack, rd_done;

  logic        rd_req, fifo_clr, frame_done, busy;
  logic [23:0] rd_addr;
  logic [10:0] rd_len;
  logic [15:0] underrun_cnt;

  logic        w_rd_req, w_fifo_clr, w_frame_done, w_busy;
  logic [23:0] w_rd_addr;
  logic [10:0] w_rd_len;
  logic [15:0] w_underrun_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [34:0] exp_q[$];
  logic [23:0] exp_w_q[$];

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    int          bursts;
    logic [10:0] last_len;
  } vec_t;

  vec_t vecs[5];

  lcd_rd_ctrl #(.ADDR_W(24), .FB_BASE(24'h000000), .BURST_LEN(128),
                .LOW_WM(512), .CLR_CYCLES(4)) dut (
    .lcd_pclk(clk), .rst(rst), .h_disp(h_disp), .v_disp(v_disp),
    .out_vsync(out_vsync), .fifo_usedw(fifo_usedw), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack), .rd_done(rd_done),
    .fifo_clr(fifo_clr), .frame_done(frame_done), .busy(busy),
    .underrun_cnt(underrun_cnt)
  );

  lcd_rd_ctrl #(.ADDR_W(24), .FB_BASE(24'hFFFF80), .BURST_LEN(128),
                .LOW_WM(512), .CLR_CYCLES(4)) dut_w (
    .lcd_pclk(clk), .rst(rst), .h_disp(h_disp), .v_disp(v_disp),
    .out_vsync(out_vsync), .fifo_usedw(fifo_usedw), .rd_req(w_rd_req),
    .rd_addr(w_rd_addr), .rd_len(w_rd_len), .rd_ack(rd_ack), .rd_done(rd_done),
    .fifo_clr(w_fifo_clr), .frame_done(w_frame_done), .busy(w_busy),
    .underrun_cnt(w_underrun_cnt)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_addr", rd_addr, 24'h000000);
    check("rst_rd_len", rd_len, 0);
    check("rst_fifo_clr", fifo_clr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun_cnt, 0);
    check("rst_w_rd_addr", w_rd_addr, 24'hFFFF80);
  endtask

  // Serve one frame: optional 3-cycle vsync pulse, rd_ack 2 cycles after
  // rd_req is seen, rd_done 4 cycles after rd_ack, until frame_done.
  task automatic run_frame(input logic [10:0] h, input logic [10:0] v,
                           input int n_bursts, input logic [10:0] last_len,
                           input bit pulse);
    int phase = 0;
    int cnt = 0;
    int nfd = 0;
    bit fin = 0;
    logic [34:0] e;
    for (int i = 0; i < n_bursts; i++) begin
      exp_q.push_back({24'(i * 128), (i == n_bursts - 1) ? last_len : 11'd128});
      exp_w_q.push_back(24'hFFFF80 + 24'(i * 128));
    end
    h_disp = h;
    v_disp = v;
    for (int t = 0; t < 20000 && !fin; t++) begin
      @(negedge clk);
      out_vsync = pulse && (t < 3);
      rd_ack = 1'b0;
      rd_done = 1'b0;
      if (frame_done) begin
        nfd++;
        fin = 1;
      end
      case (phase)
        0: if (rd_req) begin
          if (exp_q.size() == 0) begin
            check("unexpected_req", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("burst_addr_len", {rd_addr, rd_len}, e);
            check("wrap_addr", w_rd_addr, exp_w_q.pop_front());
          end
          cnt = 0;
          phase = 1;
        end
        1: begin
          cnt++;
          if (cnt == 2) begin
            rd_ack = 1'b1;
            cnt = 0;
            phase = 2;
          end
        end
        default: begin
          cnt++;
          if (cnt == 4) begin
            rd_done = 1'b1;
            phase = 0;
          end
        end
      endcase
    end
    check("frame_finished", fin, 1);
    out_vsync = 1'b0;
    rd_ack = 1'b0;
    rd_done = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (frame_done) nfd++;
    end
    check("frame_done_cnt", nfd, 1);
    check("bursts_left", exp_q.size(), 0);
    check("idle_after_frame", busy, 0);
    exp_q.delete();
    exp_w_q.delete();
  endtask

  initial begin
    int clr_cnt;
    int first_req;
    int req_seen;
    bit bad;

    vecs[0] = '{h: 11'd480, v: 11'd272, bursts: 1020, last_len: 11'd128};
    vecs[1] = '{h: 11'd100, v: 11'd3,   bursts: 3,    last_len: 11'd44};
    vecs[2] = '{h: 11'd1,   v: 11'd1,   bursts: 1,    last_len: 11'd1};
    vecs[3] = '{h: 11'd0,   v: 11'd5,   bursts: 0,    last_len: 11'd0};
    vecs[4] = '{h: 11'd130, v: 11'd1,   bursts: 2,    last_len: 11'd2};

    rst = 1'b1;
    h_disp = 11'd100;
    v_disp = 11'd3;
    out_vsync = 1'b0;
    fifo_usedw = 11'd0;
    rd_ack = 1'b0;
    rd_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();

    // Held vsync from idle: one frame start, 4 clear cycles, rd_req at cycle 6.
    out_vsync = 1'b1;
    clr_cnt = 0;
    first_req = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (fifo_clr) clr_cnt++;
      if (rd_req && first_req == 0) first_req = i;
    end
    check("held_vs_clr_cycles", clr_cnt, 4);
    check("held_vs_first_req", first_req, 6);
    check("held_vs_busy", busy, 1);
    out_vsync = 1'b0;
    // Reset while a request is outstanding.
    do_reset();
    check_reset_values();

    // Watermark: no request above LOW_WM, request once below it.
    fifo_usedw = 11'd600;
    @(negedge clk);
    out_vsync = 1'b1;
    @(negedge clk);
    out_vsync = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_req) req_seen++;
    end
    check("wm_no_req", req_seen, 0);
    check("wm_busy", busy, 1);
    fifo_usedw = 11'd511;
    @(negedge clk);
    @(negedge clk);
    check("wm_req", rd_req, 1);
    check("wm_addr_len", {rd_addr, rd_len}, {24'h000000, 11'd128});
    fifo_usedw = 11'd0;
    do_reset();

    // Frame table.
    for (int k = 0; k < 5; k++) begin
      run_frame(vecs[k].h, vecs[k].v, vecs[k].bursts, vecs[k].last_len, 1'b1);
    end

    // Overrun in XFER: burst completes, then restart from FB_BASE.
    h_disp = 11'd100;
    v_disp = 11'd3;
    @(negedge clk);
    out_vsync = 1'b1;
    @(negedge clk);
    out_vsync = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 30 && req_seen == 0; i++) begin
      @(negedge clk);
      if (rd_req) req_seen = 1;
    end
    check("ovr_first_req", req_seen, 1);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check("ovr_req_dropped", rd_req, 0);
    repeat (2) @(negedge clk);
    out_vsync = 1'b1;
    @(negedge clk);
    out_vsync = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rd_req || fifo_clr || frame_done) bad = 1;
    end
    check("ovr_hold_burst", bad, 0);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    check("ovr_clr_after_done", fifo_clr, 1);
    check("ovr_no_frame_done", frame_done, 0);
`ifdef LCD_RD_UNDERRUN_CNT_EN
    check("ovr_underrun", underrun_cnt, 1);
`else
    check("ovr_underrun", underrun_cnt, 0);
`endif
    run_frame(11'd100, 11'd3, 3, 11'd44, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
